// File: rtl/fpu_alu_pipe_exec_element_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_alu_pipe_exec_element_if
// Description : Issue / completion bundle for the pipelined FP ALU exec
//               element. The master side issues ops and accepts results;
//               the slave side is the execution element.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_alu_pipe_exec_element_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 5
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic             flush;
    logic             start;
    logic             ready;
    logic [5:0]       inst_num;
    logic [W-1:0]     fs;
    logic [W-1:0]     ft;
    logic [TAG_W-1:0] tag_in;
    logic             completed;
    logic             ack;
    logic [W-1:0]     out;
    logic [TAG_W-1:0] tag_out;
    logic             exc_invalid;

    modport master (
        output flush, start, inst_num, fs, ft, tag_in, ack,
        input  ready, completed, out, tag_out, exc_invalid
    );

    modport slave (
        input  flush, start, inst_num, fs, ft, tag_in, ack,
        output ready, completed, out, tag_out, exc_invalid
    );
endinterface
`default_nettype wire

// File: rtl/fpu_alu_pipe_exec_element.sv
`default_nettype none
// ============================================================================
// Module      : fpu_alu_pipe_exec_element
// Description : Pipelined non-arithmetic FP ALU (move, neg, abs, compare,
//               min, max), generic over float format, with valid/ready
//               handshakes, per-op tag and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_alu_pipe_exec_element #(
    parameter int EXP_W   = 8,
    parameter int FRAC_W  = 23,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic clk,
    input  logic reset,
    fpu_alu_pipe_exec_element_if.slave bus
);
    localparam int W = 1 + EXP_W + FRAC_W;

    localparam logic [5:0] c_OP_FMOV = 6'd0;
    localparam logic [5:0] c_OP_FNEG = 6'd1;
    localparam logic [5:0] c_OP_FABS = 6'd2;
    localparam logic [5:0] c_OP_FEQ  = 6'd3;
    localparam logic [5:0] c_OP_FLT  = 6'd4;
    localparam logic [5:0] c_OP_FLE  = 6'd5;
    localparam logic [5:0] c_OP_FMIN = 6'd6;
    localparam logic [5:0] c_OP_FMAX = 6'd7;

    localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [W-1:0] c_SIGN = {1'b1, {(W-1){1'b0}}};

    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_any_nan;
    logic             w_both_zero, w_lt, w_eq;
    logic [W-1:0]     w_res;
    logic             w_inv;
    logic             w_adv;

    logic             valid_q [LATENCY];
    logic             valid_d [LATENCY];
    logic [W-1:0]     res_q   [LATENCY];
    logic [W-1:0]     res_d   [LATENCY];
    logic [TAG_W-1:0] tag_q   [LATENCY];
    logic [TAG_W-1:0] tag_d   [LATENCY];
    logic             exc_q   [LATENCY];
    logic             exc_d   [LATENCY];

    // Classify operands and order them as sign-magnitude values (+0 == -0)
    always_comb begin
        w_a_nan     = (&bus.fs[W-2:FRAC_W]) && (|bus.fs[FRAC_W-1:0]);
        w_b_nan     = (&bus.ft[W-2:FRAC_W]) && (|bus.ft[FRAC_W-1:0]);
        w_a_snan    = w_a_nan && !bus.fs[FRAC_W-1];
        w_b_snan    = w_b_nan && !bus.ft[FRAC_W-1];
        w_any_nan   = w_a_nan || w_b_nan;
        w_both_zero = (bus.fs[W-2:0] == '0) && (bus.ft[W-2:0] == '0);
        w_eq        = w_both_zero || (bus.fs == bus.ft);
        w_lt        = 1'b0;
        if (!w_both_zero) begin
            if (bus.fs[W-1] != bus.ft[W-1]) begin
                w_lt = bus.fs[W-1];
            end else if (!bus.fs[W-1]) begin
                w_lt = bus.fs[W-2:0] < bus.ft[W-2:0];
            end else begin
                w_lt = bus.fs[W-2:0] > bus.ft[W-2:0];
            end
        end
    end

    // Stage-0 result and invalid flag for the selected op
    always_comb begin
        w_res = '0;
        w_inv = 1'b0;
        case (bus.inst_num)
            c_OP_FMOV: w_res = bus.fs;
            c_OP_FNEG: w_res = bus.fs ^ c_SIGN;
            c_OP_FABS: w_res = bus.fs & ~c_SIGN;
            c_OP_FEQ: begin
                w_res[0] = !w_any_nan && w_eq;
                w_inv    = w_a_snan || w_b_snan;
            end
            c_OP_FLT: begin
                w_res[0] = !w_any_nan && w_lt;
                w_inv    = w_any_nan;
            end
            c_OP_FLE: begin
                w_res[0] = !w_any_nan && (w_lt || w_eq);
                w_inv    = w_any_nan;
            end
            c_OP_FMIN, c_OP_FMAX: begin
                w_inv = w_a_snan || w_b_snan;
                if (w_a_nan && w_b_nan) begin
                    w_res = c_QNAN;
                end else if (w_a_nan) begin
                    w_res = bus.ft;
                end else if (w_b_nan) begin
                    w_res = bus.fs;
                end else if (w_both_zero) begin
                    // min prefers -0, max prefers +0
                    if (bus.inst_num == c_OP_FMIN) begin
                        w_res = (bus.fs[W-1] || bus.ft[W-1]) ? c_SIGN : '0;
                    end else begin
                        w_res = (bus.fs[W-1] && bus.ft[W-1]) ? c_SIGN : '0;
                    end
                end else begin
                    w_res = (w_lt == (bus.inst_num == c_OP_FMIN)) ? bus.fs : bus.ft;
                end
            end
            default: w_inv = 1'b1;
        endcase
    end

    // The whole pipe moves only when the last stage is empty or being taken
    assign w_adv     = !valid_q[LATENCY-1] || bus.ack;
    assign bus.ready = w_adv;

    // Next-state of every stage: hold, shift on advance, flush kills valids
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            valid_d[k] = valid_q[k];
            res_d[k]   = res_q[k];
            tag_d[k]   = tag_q[k];
            exc_d[k]   = exc_q[k];
        end
        if (w_adv) begin
            valid_d[0] = bus.start;
            res_d[0]   = w_res;
            tag_d[0]   = bus.tag_in;
            exc_d[0]   = w_inv;
            for (int k = 1; k < LATENCY; k++) begin
                valid_d[k] = valid_q[k-1];
                res_d[k]   = res_q[k-1];
                tag_d[k]   = tag_q[k-1];
                exc_d[k]   = exc_q[k-1];
            end
        end
        if (bus.flush) begin
            for (int k = 0; k < LATENCY; k++) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < LATENCY; k++) begin
            if (reset) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                tag_q[k]   <= '0;
                exc_q[k]   <= 1'b0;
            end else begin
                valid_q[k] <= valid_d[k];
                res_q[k]   <= res_d[k];
                tag_q[k]   <= tag_d[k];
                exc_q[k]   <= exc_d[k];
            end
        end
    end

    assign bus.completed   = valid_q[LATENCY-1];
    assign bus.out         = res_q[LATENCY-1];
    assign bus.tag_out     = tag_q[LATENCY-1];
    assign bus.exc_invalid = exc_q[LATENCY-1];
endmodule
`default_nettype wire

// File: tb/tb_fpu_alu_pipe_exec_element.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpu_alu_pipe_exec_element
// Description : Self-checking bench for the pipelined FP ALU exec element,
//               single precision LATENCY=2 and half precision LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_alu_pipe_exec_element;
    localparam int L32 = 2;
    localparam int L16 = 1;

    localparam logic [5:0] c_FMOV = 6'd0;
    localparam logic [5:0] c_FNEG = 6'd1;
    localparam logic [5:0] c_FABS = 6'd2;
    localparam logic [5:0] c_FEQ  = 6'd3;
    localparam logic [5:0] c_FLT  = 6'd4;
    localparam logic [5:0] c_FLE  = 6'd5;
    localparam logic [5:0] c_FMIN = 6'd6;
    localparam logic [5:0] c_FMAX = 6'd7;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        inv;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fpu_alu_pipe_exec_element_if #(.EXP_W(8), .FRAC_W(23), .TAG_W(5)) if32();
    fpu_alu_pipe_exec_element_if #(.EXP_W(5), .FRAC_W(10), .TAG_W(5)) if16();

    fpu_alu_pipe_exec_element #(.EXP_W(8), .FRAC_W(23), .LATENCY(L32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .bus(if32.slave)
    );
    fpu_alu_pipe_exec_element #(.EXP_W(5), .FRAC_W(10), .LATENCY(L16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .bus(if16.slave)
    );

    // ---------------- reference model (real-valued) ----------------
    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
        else        for (int i = 0; i < -n; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real to_real(input int ew, input int fw, input logic [63:0] x);
        logic [63:0] emask = (64'd1 << ew) - 64'd1;
        logic [63:0] fmask = (64'd1 << fw) - 64'd1;
        int  e = int'((x >> fw) & emask);
        int  f = int'(x & fmask);
        int  bias = (1 << (ew - 1)) - 1;
        real mag;
        if (64'(e) == emask)  mag = 1.0e300;
        else if (e == 0)      mag = $itor(f) * pow2(1 - bias - fw);
        else                  mag = ($itor(f) + pow2(fw)) * pow2(e - bias - fw);
        return x[ew+fw] ? -mag : mag;
    endfunction

    function automatic void model(input int ew, input int fw, input logic [5:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic inv);
        logic [63:0] emask = (64'd1 << ew) - 64'd1;
        logic [63:0] fmask = (64'd1 << fw) - 64'd1;
        logic [63:0] sbit  = 64'd1 << (ew + fw);
        logic [63:0] qnan  = (emask << fw) | (64'd1 << (fw - 1));
        logic na, nb, sa, sb;
        real  ra, rb;
        na = (((a >> fw) & emask) == emask) && ((a & fmask) != 0);
        nb = (((b >> fw) & emask) == emask) && ((b & fmask) != 0);
        sa = na && (((a >> (fw - 1)) & 64'd1) == 0);
        sb = nb && (((b >> (fw - 1)) & 64'd1) == 0);
        ra = to_real(ew, fw, a);
        rb = to_real(ew, fw, b);
        r = 64'd0;
        inv = 1'b0;
        case (op)
            c_FMOV: r = a;
            c_FNEG: r = a ^ sbit;
            c_FABS: r = a & ~sbit;
            c_FEQ: begin r = {63'd0, (!na && !nb && ra == rb)}; inv = sa || sb; end
            c_FLT: begin r = {63'd0, (!na && !nb && ra <  rb)}; inv = na || nb; end
            c_FLE: begin r = {63'd0, (!na && !nb && ra <= rb)}; inv = na || nb; end
            c_FMIN, c_FMAX: begin
                inv = sa || sb;
                if (na && nb)                   r = qnan;
                else if (na)                    r = b;
                else if (nb)                    r = a;
                else if (ra == 0.0 && rb == 0.0) r = (op == c_FMIN) ? ((a | b) & sbit) : (a & b & sbit);
                else if (ra == rb)              r = a;
                else if (op == c_FMIN)          r = (ra < rb) ? a : b;
                else                            r = (ra > rb) ? a : b;
            end
            default: begin r = 64'd0; inv = 1'b1; end
        endcase
    endfunction

    function automatic logic [63:0] rand_operand(input int ew, input int fw);
        logic [63:0] emask = (64'd1 << ew) - 64'd1;
        logic [63:0] fmask = (64'd1 << fw) - 64'd1;
        logic [63:0] e, f, s;
        f = {$urandom, $urandom} & fmask;
        e = {32'd0, $urandom} % emask;
        case ($urandom_range(0, 7))
            0: begin e = 64'd0; f = 64'd0; end
            1: begin e = emask; f = 64'd0; end
            2: begin e = emask; f = f | (64'd1 << (fw - 1)); end
            3: begin e = emask; f = (f & ~(64'd1 << (fw - 1))) | 64'd1; end
            4: e = 64'd0;
            5: e = emask >> 1;
            default: ;
        endcase
        s = 64'($urandom_range(0, 1));
        return (s << (ew + fw)) | (e << fw) | f;
    endfunction

    // ---------------- pin-level helpers ----------------
    task automatic drive(input bit h, input logic st, input logic [5:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tg, input logic ak);
        if (h) begin
            if16.start = st; if16.inst_num = op; if16.fs = a[15:0]; if16.ft = b[15:0];
            if16.tag_in = tg; if16.ack = ak;
        end else begin
            if32.start = st; if32.inst_num = op; if32.fs = a[31:0]; if32.ft = b[31:0];
            if32.tag_in = tg; if32.ack = ak;
        end
    endtask

    task automatic sample(input bit h, output logic cpl, output logic rdy, output logic [63:0] o,
                          output logic [4:0] tg, output logic inv);
        if (h) begin
            cpl = if16.completed; rdy = if16.ready; o = {48'd0, if16.out};
            tg = if16.tag_out; inv = if16.exc_invalid;
        end else begin
            cpl = if32.completed; rdy = if32.ready; o = {32'd0, if32.out};
            tg = if32.tag_out; inv = if32.exc_invalid;
        end
    endtask

    // Issue one op into an empty pipe with ack=1 and check exact latency and result
    task automatic run_one(input bit h, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] tag, input logic [63:0] exp_out, input logic exp_inv,
                           input string name);
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        int lat = h ? L16 : L32;
        drive(h, 1'b1, op, a, b, tag, 1'b1);
        @(negedge clk); sample(h, cpl, rdy, o, tg, inv);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL %s_ready: ready=%b expected 1", name, rdy); end
        @(posedge clk); #1;
        drive(h, 1'b0, op, a, b, tag, 1'b1);
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk); sample(h, cpl, rdy, o, tg, inv);
            total++;
            if (cpl !== 1'b0) begin bad++; $display("FAIL %s_early: completed=%b expected 0", name, cpl); end
            @(posedge clk); #1;
        end
        @(negedge clk); sample(h, cpl, rdy, o, tg, inv);
        total++;
        if (cpl !== 1'b1 || o !== exp_out || tg !== tag || inv !== exp_inv) begin
            bad++;
            $display("FAIL %s: completed=%b out=%h tag=%h exc=%b, expected 1 %h %h %b",
                     name, cpl, o, tg, inv, exp_out, tag, exp_inv);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        if32.flush = 1'b0; if16.flush = 1'b0;
        drive(0, 1'b1, c_FNEG, 64'h3F800000, 64'd0, 5'd7, 1'b1);
        drive(1, 1'b1, c_FNEG, 64'h3C00, 64'd0, 5'd7, 1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        drive(1, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk); sample(h[0], cpl, rdy, o, tg, inv);
            total++;
            if (cpl !== 1'b0 || o !== 64'd0 || tg !== 5'd0 || inv !== 1'b0 || rdy !== 1'b1) begin
                bad++;
                $display("FAIL reset_state[%0d]: completed=%b out=%h tag=%h exc=%b ready=%b, expected 0 0 0 0 1",
                         h, cpl, o, tg, inv, rdy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        drive(0, 1'b1, c_FNEG, 64'h3F800000, 64'd0, 5'd3, 1'b1);
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready0: ready=%b expected 1", rdy); end
        @(posedge clk); #1;
        drive(0, 1'b1, c_FABS, 64'hC0400000, 64'd0, 5'd4, 1'b1);
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (rdy !== 1'b1 || cpl !== 1'b0) begin
            bad++; $display("FAIL b2b_cycle1: ready=%b completed=%b expected 1 0", rdy, cpl);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (cpl !== 1'b1 || o !== 64'hBF800000 || tg !== 5'd3 || rdy !== 1'b1) begin
            bad++; $display("FAIL b2b_first: completed=%b out=%h tag=%h ready=%b expected 1 bf800000 03 1", cpl, o, tg, rdy);
        end
        @(posedge clk); #1;
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (cpl !== 1'b1 || o !== 64'h40400000 || tg !== 5'd4) begin
            bad++; $display("FAIL b2b_second: completed=%b out=%h tag=%h expected 1 40400000 04", cpl, o, tg);
        end
        @(posedge clk); #1;
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (cpl !== 1'b0) begin bad++; $display("FAIL b2b_empty: completed=%b expected 0", cpl); end
        @(posedge clk); #1;
    endtask

    task automatic test_compare();
        run_one(0, c_FLT, 64'hBF800000, 64'h3F800000, 5'd1, 64'd1, 1'b0, "flt_neg_pos");
        run_one(0, c_FLE, 64'h7FC00000, 64'h0,        5'd2, 64'd0, 1'b1, "fle_qnan");
        run_one(0, c_FEQ, 64'h00000000, 64'h80000000, 5'd3, 64'd1, 1'b0, "feq_zeros");
        run_one(0, c_FEQ, 64'h7F800001, 64'h0,        5'd4, 64'd0, 1'b1, "feq_snan");
    endtask

    task automatic test_minmax();
        run_one(0, c_FMIN, 64'h7FC00000, 64'h40000000, 5'd5, 64'h40000000, 1'b0, "fmin_one_nan");
        run_one(0, c_FMAX, 64'h7FC00000, 64'h7F800001, 5'd6, 64'h7FC00000, 1'b1, "fmax_two_nan");
        run_one(0, c_FMIN, 64'h00000000, 64'h80000000, 5'd7, 64'h80000000, 1'b0, "fmin_zeros");
        run_one(0, c_FMAX, 64'h80000000, 64'h00000000, 5'd8, 64'h00000000, 1'b0, "fmax_zeros");
    endtask

    task automatic test_illegal();
        run_one(0, 6'd9, 64'h3F800000, 64'h40000000, 5'd9, 64'd0, 1'b1, "illegal_op");
    endtask

    task automatic test_half();
        run_one(1, c_FLT,  64'hBC00, 64'h3C00, 5'd11, 64'd1,    1'b0, "h_flt");
        run_one(1, c_FMIN, 64'h7E00, 64'h4000, 5'd12, 64'h4000, 1'b0, "h_fmin_nan");
        run_one(1, c_FMIN, 64'h0000, 64'h8000, 5'd13, 64'h8000, 1'b0, "h_fmin_zeros");
        run_one(1, c_FMAX, 64'h7E00, 64'h7C01, 5'd14, 64'h7E00, 1'b1, "h_fmax_snan");
    endtask

    task automatic test_backpressure();
        logic [5:0]  ops [3];
        logic [63:0] av [3];
        logic [63:0] bv [3];
        exp_t        ev [3];
        logic [63:0] r; logic ri;
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        int sent = 0, got = 0;
        ops = '{c_FNEG, c_FABS, c_FMAX};
        av  = '{64'h3F800000, 64'hC0400000, 64'h3F800000};
        bv  = '{64'h0, 64'h0, 64'h40000000};
        for (int i = 0; i < 3; i++) begin
            model(8, 23, ops[i], av[i], bv[i], r, ri);
            ev[i].res = r; ev[i].inv = ri; ev[i].tag = 5'(10 + i);
        end
        for (int c = 0; c < 8; c++) begin
            if (sent < 3) drive(0, 1'b1, ops[sent], av[sent], bv[sent], ev[sent].tag, 1'b0);
            else          drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b0);
            @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
            if (c >= 2) begin
                total++;
                if (cpl !== 1'b1 || o !== ev[0].res || tg !== ev[0].tag || rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_hold c%0d: completed=%b out=%h tag=%h ready=%b expected 1 %h %h 0",
                             c, cpl, o, tg, rdy, ev[0].res, ev[0].tag);
                end
            end
            if (sent < 3 && rdy === 1'b1) sent++;
            @(posedge clk); #1;
        end
        total++;
        if (sent != 2) begin bad++; $display("FAIL bp_fill: accepted=%0d expected 2", sent); end
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (sent < 3) drive(0, 1'b1, ops[sent], av[sent], bv[sent], ev[sent].tag, 1'b1);
            else          drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
            @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
            if (cpl === 1'b1) begin
                total++;
                if (o !== ev[got].res || tg !== ev[got].tag || inv !== ev[got].inv) begin
                    bad++;
                    $display("FAIL bp_drain[%0d]: out=%h tag=%h exc=%b expected %h %h %b",
                             got, o, tg, inv, ev[got].res, ev[got].tag, ev[got].inv);
                end
                got++;
            end
            if (sent < 3 && rdy === 1'b1) sent++;
            @(posedge clk); #1;
        end
        total++;
        if (got != 3) begin bad++; $display("FAIL bp_count: drained=%0d expected 3", got); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
            total++;
            if (cpl !== 1'b0) begin bad++; $display("FAIL bp_dup: completed=%b expected 0", cpl); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        drive(0, 1'b1, c_FMOV, 64'h11111111, 64'd0, 5'd1, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, c_FMOV, 64'h22222222, 64'd0, 5'd2, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, c_FMOV, 64'h33333333, 64'd0, 5'd3, 1'b1);
        if32.flush = 1'b1;
        @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
        total++;
        if (cpl !== 1'b1) begin bad++; $display("FAIL flush_inflight: completed=%b expected 1", cpl); end
        @(posedge clk); #1;
        if32.flush = 1'b0;
        drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
            total++;
            if (cpl !== 1'b0) begin bad++; $display("FAIL flush_kill c%0d: completed=%b out=%h expected 0", c, cpl, o); end
            @(posedge clk); #1;
        end
        run_one(0, c_FNEG, 64'h40000000, 64'd0, 5'd17, 64'hC0000000, 1'b0, "after_flush");
    endtask

    task automatic test_reset_midop();
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        drive(0, 1'b1, c_FMOV, 64'h55555555, 64'd0, 5'd21, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); sample(0, cpl, rdy, o, tg, inv);
            total++;
            if (cpl !== 1'b0) begin bad++; $display("FAIL reset_midop c%0d: completed=%b expected 0", c, cpl); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input bit h, input int n);
        exp_t q[$];
        exp_t e;
        int ew = h ? 5 : 8;
        int fw = h ? 10 : 23;
        int sent = 0, got = 0, cyc = 0;
        logic st, ak; logic [5:0] op; logic [63:0] a, b; logic [4:0] tgi;
        logic cpl, rdy, inv; logic [63:0] o; logic [4:0] tg;
        while (got < n && cyc < n * 20) begin
            st = (sent < n) && ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            a  = rand_operand(ew, fw);
            case ($urandom_range(0, 7))
                0, 1:    b = a;
                2:       b = a ^ (64'd1 << (ew + fw));
                default: b = rand_operand(ew, fw);
            endcase
            tgi = 5'($urandom);
            ak  = ($urandom_range(0, 9) < 7);
            drive(h, st, op, a, b, tgi, ak);
            @(negedge clk); sample(h, cpl, rdy, o, tg, inv);
            total++;
            if (rdy !== (!cpl || ak)) begin
                bad++; $display("FAIL rand%0d_ready: ready=%b expected %b", h, rdy, (!cpl || ak));
            end
            if (cpl === 1'b1 && ak) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand%0d_extra: out=%h tag=%h with nothing expected", h, o, tg);
                end else begin
                    e = q.pop_front();
                    if (o !== e.res || tg !== e.tag || inv !== e.inv) begin
                        bad++;
                        $display("FAIL rand%0d_result: out=%h tag=%h exc=%b expected %h %h %b",
                                 h, o, tg, inv, e.res, e.tag, e.inv);
                    end
                end
                got++;
            end
            if (st && rdy === 1'b1) begin
                model(ew, fw, op, a, b, e.res, e.inv);
                e.tag = tgi;
                q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        drive(h, 1'b0, c_FMOV, 64'd0, 64'd0, 5'd0, 1'b1);
        total++;
        if (got != n || q.size() != 0) begin
            bad++; $display("FAIL rand%0d_drain: got=%0d expected %0d, left=%0d", h, got, n, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_compare();
        test_minmax();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_half();
        test_random(1'b0, 300);
        test_random(1'b1, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
